// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundles the MEM-stage, host and data-memory signals handled
//               by the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ARQ      = 16,
    parameter int MEM_ADDR = 10
);
    // MEM-stage side
    logic                cpu_rd;
    logic                cpu_wr;
    logic [MEM_ADDR-1:0] cpu_addr;
    logic [ARQ-1:0]      cpu_wdata;
    logic [ARQ-1:0]      cpu_rdata;
    logic                cpu_stall;

    // Host side
    logic                host_req;
    logic                host_we;
    logic                host_lock;
    logic [MEM_ADDR-1:0] host_addr;
    logic [ARQ-1:0]      host_wdata;
    logic                host_gnt;
    logic                host_rvalid;
    logic [ARQ-1:0]      host_rdata;

    // Data-memory side
    logic                mem_rd_en;
    logic                mem_wr_en;
    logic [MEM_ADDR-1:0] mem_addr;
    logic [ARQ-1:0]      mem_wdata;
    logic [ARQ-1:0]      mem_rdata;

    // Arbiter view
    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_lock, host_addr, host_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall,
        output host_gnt, host_rvalid, host_rdata,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );

    // Requesters and memory view
    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output host_req, host_we, host_lock, host_addr, host_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Per-cycle arbiter sharing the single-port data memory between
//               the pipeline MEM stage and a host port, with starvation
//               guard, host burst lock and read-data return routing.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ARQ        = 16,
    parameter int MEM_ADDR   = 10,
    parameter int STARVE_LIM = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dmem_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_SHARED = 1'b0,
        ST_LOCK   = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    localparam logic [3:0]          c_starve_lim = 4'(STARVE_LIM);
    localparam logic [3:0]          c_wait_max   = 4'hF;
    localparam logic [ARQ-1:0]      c_zero_data  = '0;
    localparam logic [MEM_ADDR-1:0] c_zero_addr  = '0;

    state_t              r_state;
    owner_t              r_rd_owner;
    logic [3:0]          r_wait_cnt;
    logic                r_host_rvalid;
    logic [ARQ-1:0]      r_host_rdata;
    logic [ARQ-1:0]      r_cpu_rdata;

    logic                w_cpu_req;
    logic                w_cpu_win;
    logic                w_host_win;
    logic                w_mem_rd_en;
    logic                w_mem_wr_en;
    logic [MEM_ADDR-1:0] w_mem_addr;
    logic [ARQ-1:0]      w_mem_wdata;

    assign w_cpu_req = bus.cpu_rd | bus.cpu_wr;

    // Grant decision; everything is forced idle while reset is held.
    always_comb begin
        w_cpu_win  = 1'b0;
        w_host_win = 1'b0;
        if (!rst) begin
            if (r_state == ST_LOCK) begin
                w_host_win = bus.host_req;
            end else begin
                w_cpu_win  = w_cpu_req &&
                             (!bus.host_req || (r_wait_cnt < c_starve_lim));
                w_host_win = bus.host_req && !w_cpu_win;
            end
        end
    end

    // A simultaneous cpu_rd/cpu_wr is treated as a write.
    always_comb begin
        w_mem_rd_en = 1'b0;
        w_mem_wr_en = 1'b0;
        w_mem_addr  = c_zero_addr;
        w_mem_wdata = c_zero_data;
        if (w_cpu_win) begin
            w_mem_wr_en = bus.cpu_wr;
            w_mem_rd_en = !bus.cpu_wr;
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
        end else if (w_host_win) begin
            w_mem_wr_en = bus.host_we;
            w_mem_rd_en = !bus.host_we;
            w_mem_addr  = bus.host_addr;
            w_mem_wdata = bus.host_wdata;
        end
    end

    assign bus.cpu_stall   = !rst && w_cpu_req && !w_cpu_win;
    assign bus.host_gnt    = w_host_win;
    assign bus.mem_rd_en   = w_mem_rd_en;
    assign bus.mem_wr_en   = w_mem_wr_en;
    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wdata   = w_mem_wdata;
    assign bus.cpu_rdata   = r_cpu_rdata;
    assign bus.host_rvalid = r_host_rvalid;
    assign bus.host_rdata  = r_host_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_SHARED;
            r_wait_cnt    <= 4'd0;
            r_rd_owner    <= OWN_NONE;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= c_zero_data;
            r_cpu_rdata   <= c_zero_data;
        end else begin
            if (r_state == ST_SHARED) begin
                if (w_host_win && bus.host_lock) begin
                    r_state <= ST_LOCK;
                end
            end else if (!bus.host_lock) begin
                r_state <= ST_SHARED;
            end

            // Counts host cycles lost to the CPU; saturates rather than wraps.
            if (bus.host_req && w_cpu_win) begin
                if (r_wait_cnt != c_wait_max) begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
            end else begin
                r_wait_cnt <= 4'd0;
            end

            if (w_mem_rd_en) begin
                r_rd_owner <= w_cpu_win ? OWN_CPU : OWN_HOST;
            end else begin
                r_rd_owner <= OWN_NONE;
            end

            // mem_rdata belongs to the read issued one cycle earlier.
            r_host_rvalid <= (r_rd_owner == OWN_HOST);
            if (r_rd_owner == OWN_HOST) begin
                r_host_rdata <= bus.mem_rdata;
            end
            if (r_rd_owner == OWN_CPU) begin
                r_cpu_rdata <= bus.mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a memory model and
//               a read-return scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ARQ        = 16;
    localparam int MEM_ADDR   = 10;
    localparam int STARVE_LIM = 4;

    typedef struct {
        int             due;
        logic [ARQ-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;
    exp_t cpu_q[$];
    exp_t host_q[$];
    logic [ARQ-1:0] cpu_last = '0;
    logic [ARQ-1:0] mem [0:(1<<MEM_ADDR)-1];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ARQ(ARQ), .MEM_ADDR(MEM_ADDR)) bus ();

    dmem_arbiter #(
        .ARQ        (ARQ),
        .MEM_ADDR   (MEM_ADDR),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-port synchronous memory, read data valid the cycle after rd_en
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic rd, input logic wr, input logic [9:0] addr, input logic [15:0] wdata);
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    task automatic set_host(input logic req, input logic we, input logic lock,
                            input logic [9:0] addr, input logic [15:0] wdata);
        bus.host_req   = req;
        bus.host_we    = we;
        bus.host_lock  = lock;
        bus.host_addr  = addr;
        bus.host_wdata = wdata;
    endtask

    task automatic push_cpu(input logic [15:0] d);
        cpu_q.push_back('{due: edge_cnt + 2, data: d});
    endtask

    task automatic push_host(input logic [15:0] d);
        host_q.push_back('{due: edge_cnt + 2, data: d});
    endtask

    // Checks this cycle's combinational outputs, then advances to the next negedge.
    task automatic tick(input string tag, input logic gnt, input logic stall,
                        input logic rd, input logic wr, input logic [9:0] addr, input logic [15:0] wdata);
        #1;
        check($sformatf("%s.host_gnt", tag),  bus.host_gnt,  gnt);
        check($sformatf("%s.cpu_stall", tag), bus.cpu_stall, stall);
        check($sformatf("%s.mem_rd_en", tag), bus.mem_rd_en, rd);
        check($sformatf("%s.mem_wr_en", tag), bus.mem_wr_en, wr);
        check($sformatf("%s.mem_addr", tag),  bus.mem_addr,  addr);
        check($sformatf("%s.mem_wdata", tag), bus.mem_wdata, wdata);
        @(negedge clk);
    endtask

    // Return-path monitor: registered outputs checked just after each edge
    always @(posedge clk) begin
        #1;
        edge_cnt++;
        if (rst) begin
            cpu_last = '0;
            cpu_q.delete();
            host_q.delete();
            check("rst.cpu_rdata",   bus.cpu_rdata,   16'h0);
            check("rst.host_rvalid", bus.host_rvalid, 1'b0);
            check("rst.host_rdata",  bus.host_rdata,  16'h0);
        end else begin
            if (cpu_q.size() > 0) begin
                if (cpu_q[0].due == edge_cnt) begin
                    cpu_last = cpu_q[0].data;
                    void'(cpu_q.pop_front());
                end
            end
            check("cpu_rdata", bus.cpu_rdata, cpu_last);
            if ((host_q.size() > 0) && (host_q[0].due == edge_cnt)) begin
                check("host_rvalid", bus.host_rvalid, 1'b1);
                check("host_rdata",  bus.host_rdata,  host_q[0].data);
                void'(host_q.pop_front());
            end else begin
                check("host_rvalid_idle", bus.host_rvalid, 1'b0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Requests during reset must not reach the memory
        set_cpu(1'b1, 1'b0, 10'h005, 16'h0);
        set_host(1'b1, 1'b0, 1'b1, 10'h006, 16'h0);
        tick("reset0", 0, 0, 0, 0, 10'h0, 16'h0);
        tick("reset1", 0, 0, 0, 0, 10'h0, 16'h0);
        rst = 1'b0;
        set_cpu(1'b0, 1'b0, 10'h0, 16'h0);
        set_host(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        tick("idle", 0, 0, 0, 0, 10'h0, 16'h0);

        // CPU only
        set_cpu(1'b0, 1'b1, 10'h005, 16'h1234);
        tick("cpu_wr", 0, 0, 0, 1, 10'h005, 16'h1234);
        set_cpu(1'b1, 1'b0, 10'h005, 16'h0);
        push_cpu(16'h1234);
        tick("cpu_rd", 0, 0, 1, 0, 10'h005, 16'h0);
        set_cpu(1'b0, 1'b0, 10'h0, 16'h0);
        tick("idle", 0, 0, 0, 0, 10'h0, 16'h0);

        // Host only
        set_host(1'b1, 1'b1, 1'b0, 10'h3FF, 16'hBEEF);
        tick("host_wr", 1, 0, 0, 1, 10'h3FF, 16'hBEEF);
        set_host(1'b1, 1'b0, 1'b0, 10'h3FF, 16'h0);
        push_host(16'hBEEF);
        tick("host_rd", 1, 0, 1, 0, 10'h3FF, 16'h0);
        set_host(1'b1, 1'b1, 1'b0, 10'h010, 16'h00AA);
        tick("preload0", 1, 0, 0, 1, 10'h010, 16'h00AA);
        set_host(1'b1, 1'b1, 1'b0, 10'h011, 16'h00BB);
        tick("preload1", 1, 0, 0, 1, 10'h011, 16'h00BB);

        // Starvation: CPU wins STARVE_LIM cycles, then host is forced through
        set_cpu(1'b1, 1'b0, 10'h010, 16'h0);
        set_host(1'b1, 1'b0, 1'b0, 10'h011, 16'h0);
        for (int i = 0; i < STARVE_LIM; i++) begin
            push_cpu(16'h00AA);
            tick("starve_cpu", 0, 0, 1, 0, 10'h010, 16'h0);
        end
        push_host(16'h00BB);
        tick("starve_host", 1, 1, 1, 0, 10'h011, 16'h0);
        set_host(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        push_cpu(16'h00AA);
        tick("starve_resume", 0, 0, 1, 0, 10'h010, 16'h0);

        // Withdrawn host request clears the starvation count
        set_host(1'b1, 1'b0, 1'b0, 10'h011, 16'h0);
        for (int i = 0; i < STARVE_LIM - 1; i++) begin
            push_cpu(16'h00AA);
            tick("partial_cpu", 0, 0, 1, 0, 10'h010, 16'h0);
        end
        set_host(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        push_cpu(16'h00AA);
        tick("host_drop", 0, 0, 1, 0, 10'h010, 16'h0);
        set_host(1'b1, 1'b0, 1'b0, 10'h011, 16'h0);
        for (int i = 0; i < STARVE_LIM; i++) begin
            push_cpu(16'h00AA);
            tick("recount_cpu", 0, 0, 1, 0, 10'h010, 16'h0);
        end
        push_host(16'h00BB);
        tick("recount_host", 1, 1, 1, 0, 10'h011, 16'h0);
        set_cpu(1'b0, 1'b0, 10'h0, 16'h0);
        set_host(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        tick("idle", 0, 0, 0, 0, 10'h0, 16'h0);

        // Alternating read owners on consecutive cycles
        set_cpu(1'b1, 1'b0, 10'h010, 16'h0);
        push_cpu(16'h00AA);
        tick("alt_cpu0", 0, 0, 1, 0, 10'h010, 16'h0);
        set_cpu(1'b0, 1'b0, 10'h0, 16'h0);
        set_host(1'b1, 1'b0, 1'b0, 10'h011, 16'h0);
        push_host(16'h00BB);
        tick("alt_host0", 1, 0, 1, 0, 10'h011, 16'h0);
        set_cpu(1'b1, 1'b0, 10'h011, 16'h0);
        set_host(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        push_cpu(16'h00BB);
        tick("alt_cpu1", 0, 0, 1, 0, 10'h011, 16'h0);
        set_cpu(1'b0, 1'b0, 10'h0, 16'h0);
        set_host(1'b1, 1'b0, 1'b0, 10'h010, 16'h0);
        push_host(16'h00AA);
        tick("alt_host1", 1, 0, 1, 0, 10'h010, 16'h0);
        set_host(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        tick("idle", 0, 0, 0, 0, 10'h0, 16'h0);

        // Locked burst of 8 writes against a continuous CPU read
        set_cpu(1'b1, 1'b0, 10'h010, 16'h0);
        set_host(1'b1, 1'b1, 1'b1, 10'h000, 16'hC000);
        for (int i = 0; i < STARVE_LIM; i++) begin
            push_cpu(16'h00AA);
            tick("lock_wait", 0, 0, 1, 0, 10'h010, 16'h0);
        end
        for (int i = 0; i < 8; i++) begin
            set_host(1'b1, 1'b1, (i != 7), 10'(i), 16'hC000 + 16'(i));
            tick("lock_burst", 1, 1, 0, 1, 10'(i), 16'hC000 + 16'(i));
        end
        set_host(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        push_cpu(16'h00AA);
        tick("lock_exit", 0, 0, 1, 0, 10'h010, 16'h0);
        set_cpu(1'b0, 1'b0, 10'h0, 16'h0);
        set_host(1'b1, 1'b0, 1'b0, 10'h003, 16'h0);
        push_host(16'hC003);
        tick("burst_rd3", 1, 0, 1, 0, 10'h003, 16'h0);
        set_host(1'b1, 1'b0, 1'b0, 10'h007, 16'h0);
        push_host(16'hC007);
        tick("burst_rd7", 1, 0, 1, 0, 10'h007, 16'h0);

        // Reset in the middle of a lock with a host read outstanding
        set_host(1'b1, 1'b1, 1'b1, 10'h020, 16'h5555);
        tick("lk_enter", 1, 0, 0, 1, 10'h020, 16'h5555);
        set_host(1'b0, 1'b0, 1'b1, 10'h0, 16'h0);
        set_cpu(1'b1, 1'b0, 10'h010, 16'h0);
        tick("lk_idle", 0, 1, 0, 0, 10'h0, 16'h0);
        set_host(1'b1, 1'b0, 1'b1, 10'h010, 16'h0);
        tick("lk_rd", 1, 1, 1, 0, 10'h010, 16'h0);
        rst = 1'b1;
        tick("lk_rst", 0, 0, 0, 0, 10'h0, 16'h0);
        rst = 1'b0;
        set_cpu(1'b1, 1'b0, 10'h011, 16'h0);
        push_cpu(16'h00BB);
        tick("post_rst", 0, 0, 1, 0, 10'h011, 16'h0);
        set_cpu(1'b0, 1'b0, 10'h0, 16'h0);
        set_host(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick("drain", 0, 0, 0, 0, 10'h0, 16'h0);
        end

        check("cpu_q_drained",  cpu_q.size(),  0);
        check("host_q_drained", host_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
